// File: rtl/apu_pwr_seq.sv
// APU card power sequencer: walks the rails from standby to S0 and back,
// gating each enable on the previous power-good and timing out every wait.
module apu_pwr_seq #(
  parameter logic [15:0] RSM_DLY = 16'd5560,
  parameter logic [15:0] TMO     = 16'd55600,
  parameter logic [15:0] PGD_DLY = 16'd11120,
  parameter logic [15:0] OFF_DLY = 16'd556
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       slp_s3_n,
  input  logic       slp_s5_n,
  input  logic       ddr_pwrok,
  input  logic       v1v8_pwrgd,
  input  logic       v1_pwrgd,
  input  logic       apu_vdd_pwrgd,
  input  logic       fault_clr,
  output logic       rsmrst_n,
  output logic       ddr_slp_s3_n,
  output logic       ddr_slp_s5_n,
  output logic       vrs_on,
  output logic       apu_vrm_en,
  output logic       sys_pwrgd,
  output logic       discharge_s3_n,
  output logic       discharge_s5_n,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    ST_OFF      = 4'd0,
    ST_RSM_WAIT = 4'd1,
    ST_S5       = 4'd2,
    ST_DDR_ON   = 4'd3,
    ST_S3       = 4'd4,
    ST_RAILS    = 4'd5,
    ST_VRM      = 4'd6,
    ST_PGD_DLY  = 4'd7,
    ST_S0       = 4'd8,
    ST_DOWN_S0  = 4'd9,
    ST_FAULT    = 4'd15
  } state_t;

  state_t      cur_state;
  state_t      next_state;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic [2:0]  fault_cause;
  logic [6:0]  sync1;
  logic [6:0]  sync2;
  logic        en_s;
  logic        s3_s;
  logic        s5_s;
  logic        ddr_s;
  logic        v1v8_s;
  logic        v1_s;
  logic        apu_s;
  logic        tmo_hit;

  logic        rsmrst_nxt;
  logic        ddr_s3_nxt;
  logic        ddr_s5_nxt;
  logic        vrs_nxt;
  logic        vrm_nxt;
  logic        pgd_nxt;
  logic        dis_s3_nxt;
  logic        dis_s5_nxt;

  // Board signals arrive asynchronously to osc; fault_clr is already osc-domain.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enable, slp_s3_n, slp_s5_n, ddr_pwrok, v1v8_pwrgd, v1_pwrgd, apu_vdd_pwrgd};
      sync2 <= sync1;
    end
  end

  assign {en_s, s3_s, s5_s, ddr_s, v1v8_s, v1_s, apu_s} = sync2;
  assign tmo_hit = (timer == 16'd0);
  assign state   = cur_state;

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cur_state  <= ST_OFF;
      timer      <= '0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      cur_state <= next_state;
      timer     <= timer_nxt;
      fault     <= (next_state == ST_FAULT);
      if (next_state == ST_FAULT && cur_state != ST_FAULT)
        fault_code <= fault_cause;
    end
  end

  // Sleep requests beat timeouts; a satisfied wait condition beats its timeout.
  always_comb begin
    next_state  = cur_state;
    fault_cause = 3'd0;
    case (cur_state)
      ST_OFF:      if (en_s) next_state = ST_RSM_WAIT;
      ST_RSM_WAIT: if (tmo_hit) next_state = ST_S5;
      ST_S5:       if (s5_s) next_state = ST_DDR_ON;
      ST_DDR_ON: begin
        if (ddr_s) next_state = ST_S3;
        else if (!s5_s) next_state = ST_S5;
        else if (tmo_hit) begin
          next_state  = ST_FAULT;
          fault_cause = 3'd1;
        end
      end
      ST_S3: begin
        if (s3_s) next_state = ST_RAILS;
        else if (!s5_s) next_state = ST_S5;
        else if (!ddr_s) begin
          next_state  = ST_FAULT;
          fault_cause = 3'd4;
        end
      end
      ST_RAILS: begin
        if (!s3_s) next_state = ST_DOWN_S0;
        else if (v1v8_s && v1_s) next_state = ST_VRM;
        else if (tmo_hit) begin
          next_state  = ST_FAULT;
          fault_cause = 3'd2;
        end
      end
      ST_VRM: begin
        if (!s3_s) next_state = ST_DOWN_S0;
        else if (apu_s) next_state = ST_PGD_DLY;
        else if (tmo_hit) begin
          next_state  = ST_FAULT;
          fault_cause = 3'd3;
        end
      end
      ST_PGD_DLY: begin
        if (!s3_s) next_state = ST_DOWN_S0;
        else if (tmo_hit) next_state = ST_S0;
      end
      ST_S0: begin
        if (!(ddr_s && v1v8_s && v1_s && apu_s)) begin
          next_state  = ST_FAULT;
          fault_cause = 3'd4;
        end else if (!s3_s) next_state = ST_DOWN_S0;
      end
      ST_DOWN_S0:  if (tmo_hit) next_state = ST_S3;
      ST_FAULT:    if (fault_clr && !s5_s) next_state = ST_S5;
      default:     next_state = ST_OFF;
    endcase
    if (!en_s) next_state = ST_OFF;
  end

  // The timer is reloaded on every state entry, otherwise it counts down to 0 and holds.
  always_comb begin
    timer_nxt = timer;
    if (next_state != cur_state) begin
      case (next_state)
        ST_RSM_WAIT:                 timer_nxt = RSM_DLY - 16'd1;
        ST_DDR_ON, ST_RAILS, ST_VRM: timer_nxt = TMO - 16'd1;
        ST_PGD_DLY:                  timer_nxt = PGD_DLY - 16'd1;
        ST_DOWN_S0:                  timer_nxt = OFF_DLY - 16'd1;
        default:                     timer_nxt = 16'd0;
      endcase
    end else if (!tmo_hit) begin
      timer_nxt = timer - 16'd1;
    end
  end

  always_comb begin
    rsmrst_nxt = 1'b0;
    ddr_s3_nxt = 1'b0;
    ddr_s5_nxt = 1'b0;
    vrs_nxt    = 1'b0;
    vrm_nxt    = 1'b0;
    pgd_nxt    = 1'b0;
    dis_s3_nxt = 1'b0;
    dis_s5_nxt = 1'b0;
    case (next_state)
      ST_S5, ST_FAULT: rsmrst_nxt = 1'b1;
      ST_DDR_ON, ST_S3: begin
        rsmrst_nxt = 1'b1;
        ddr_s3_nxt = 1'b1;
        ddr_s5_nxt = 1'b1;
        dis_s5_nxt = 1'b1;
      end
      ST_RAILS, ST_VRM, ST_PGD_DLY, ST_S0, ST_DOWN_S0: begin
        rsmrst_nxt = 1'b1;
        ddr_s3_nxt = 1'b1;
        ddr_s5_nxt = 1'b1;
        dis_s5_nxt = 1'b1;
        vrs_nxt    = 1'b1;
        dis_s3_nxt = 1'b1;
        vrm_nxt    = (next_state == ST_VRM) || (next_state == ST_PGD_DLY) || (next_state == ST_S0);
        pgd_nxt    = (next_state == ST_S0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      rsmrst_n       <= 1'b0;
      ddr_slp_s3_n   <= 1'b0;
      ddr_slp_s5_n   <= 1'b0;
      vrs_on         <= 1'b0;
      apu_vrm_en     <= 1'b0;
      sys_pwrgd      <= 1'b0;
      discharge_s3_n <= 1'b0;
      discharge_s5_n <= 1'b0;
    end else begin
      rsmrst_n       <= rsmrst_nxt;
      ddr_slp_s3_n   <= ddr_s3_nxt;
      ddr_slp_s5_n   <= ddr_s5_nxt;
      vrs_on         <= vrs_nxt;
      apu_vrm_en     <= vrm_nxt;
      sys_pwrgd      <= pgd_nxt;
      discharge_s3_n <= dis_s3_nxt;
      discharge_s5_n <= dis_s5_nxt;
    end
  end

endmodule

// File: tb/tb_apu_pwr_seq.sv
// Bench for apu_pwr_seq: a rail model answers each enable after 5 cycles and
// a state scoreboard checks every state transition in order.
module tb_apu_pwr_seq;

  logic       osc = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       slp_s3_n = 1'b0;
  logic       slp_s5_n = 1'b0;
  logic       ddr_pwrok = 1'b0;
  logic       v1v8_pwrgd = 1'b0;
  logic       v1_pwrgd = 1'b0;
  logic       apu_vdd_pwrgd = 1'b0;
  logic       fault_clr = 1'b0;
  logic       rsmrst_n;
  logic       ddr_slp_s3_n;
  logic       ddr_slp_s5_n;
  logic       vrs_on;
  logic       apu_vrm_en;
  logic       sys_pwrgd;
  logic       discharge_s3_n;
  logic       discharge_s5_n;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ddr_cnt = 0;
  int rail_cnt = 0;
  int apu_cnt = 0;
  logic hold_ddr = 1'b0;
  logic hold_v1 = 1'b0;
  logic hold_apu = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_prev = 4'd0;
  logic [3:0] mon_exp = 4'd0;
  logic       mon_vrm_prev = 1'b0;

  apu_pwr_seq #(
    .RSM_DLY(16'd4),
    .TMO(16'd20),
    .PGD_DLY(16'd8),
    .OFF_DLY(16'd3)
  ) dut (
    .osc(osc),
    .rst_n(rst_n),
    .enable(enable),
    .slp_s3_n(slp_s3_n),
    .slp_s5_n(slp_s5_n),
    .ddr_pwrok(ddr_pwrok),
    .v1v8_pwrgd(v1v8_pwrgd),
    .v1_pwrgd(v1_pwrgd),
    .apu_vdd_pwrgd(apu_vdd_pwrgd),
    .fault_clr(fault_clr),
    .rsmrst_n(rsmrst_n),
    .ddr_slp_s3_n(ddr_slp_s3_n),
    .ddr_slp_s5_n(ddr_slp_s5_n),
    .vrs_on(vrs_on),
    .apu_vrm_en(apu_vrm_en),
    .sys_pwrgd(sys_pwrgd),
    .discharge_s3_n(discharge_s3_n),
    .discharge_s5_n(discharge_s5_n),
    .fault(fault),
    .fault_code(fault_code),
    .state(state)
  );

  always #5 osc = ~osc;
  always @(posedge osc) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outVec();
    return {rsmrst_n, ddr_slp_s3_n, ddr_slp_s5_n, vrs_on,
            apu_vrm_en, sys_pwrgd, discharge_s3_n, discharge_s5_n};
  endfunction

  // Every state change the DUT makes must be the next one the stimulus queued.
  always @(negedge osc) begin
    if (state !== mon_prev) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("state_seq", 32'(state), 32'(mon_exp));
      end else begin
        checkOutput("state_extra", 32'(state), 32'(mon_prev));
      end
      mon_prev = state;
    end
    if (apu_vrm_en && !mon_vrm_prev)
      checkOutput("vrm_gate", 32'({v1v8_pwrgd, v1_pwrgd}), 32'd3);
    mon_vrm_prev = apu_vrm_en;
  end

  task automatic stepCycle();
    @(posedge osc);
    #1;
    if (ddr_slp_s5_n) begin if (ddr_cnt < 5) ddr_cnt++; end else ddr_cnt = 0;
    if (vrs_on) begin if (rail_cnt < 5) rail_cnt++; end else rail_cnt = 0;
    if (apu_vrm_en) begin if (apu_cnt < 5) apu_cnt++; end else apu_cnt = 0;
    ddr_pwrok     = (ddr_cnt >= 5) && !hold_ddr;
    v1v8_pwrgd    = (rail_cnt >= 5);
    v1_pwrgd      = (rail_cnt >= 5) && !hold_v1;
    apu_vdd_pwrgd = (apu_cnt >= 5) && !hold_apu;
  endtask

  task automatic applyStimulus(input logic en, input logic s5, input logic s3);
    enable   = en;
    slp_s5_n = s5;
    slp_s3_n = s3;
  endtask

  task automatic waitState(input logic [3:0] tgt, input string tag, output int at);
    int n = 0;
    while (state !== tgt && n < 200) begin
      stepCycle();
      n++;
    end
    at = cyc;
    checkOutput(tag, 32'(state), 32'(tgt));
  endtask

  task automatic pulseClear();
    fault_clr = 1'b1;
    stepCycle();
    fault_clr = 1'b0;
  endtask

  initial begin
    int e1, e2, e7, e8, ed, e4, e5, ef, eb, es, ek, eo, ex;
    #2 rst_n = 1'b0;
    repeat (3) stepCycle();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_outs", 32'(outVec()), 32'h00);
    checkOutput("rst_fault", 32'({fault, fault_code}), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] full power-up");
    for (int s = 1; s <= 8; s++) exp_q.push_back(4'(s));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd1, "up_rsm_wait", e1);
    waitState(4'd2, "up_s5", e2);
    checkOutput("rsm_dly", 32'(e2 - e1), 32'd4);
    checkOutput("s5_outs", 32'(outVec()), 32'h80);
    waitState(4'd7, "up_pgd", e7);
    waitState(4'd8, "up_s0", e8);
    checkOutput("pgd_dly", 32'(e8 - e7), 32'd8);
    checkOutput("s0_outs", 32'(outVec()), 32'hFF);

    $display("[TB] S0 to S3 and back");
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(4'd9, "dn_s0", ed);
    checkOutput("dn_outs", 32'(outVec()), 32'hF3);
    waitState(4'd4, "dn_s3", e4);
    checkOutput("off_dly", 32'(e4 - ed), 32'd3);
    checkOutput("s3_outs", 32'(outVec()), 32'hE1);
    for (int s = 5; s <= 8; s++) exp_q.push_back(4'(s));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd8, "re_s0", ex);
    checkOutput("re_sys", 32'(sys_pwrgd), 32'd1);

    $display("[TB] rail timeout");
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(4'd4, "tmo_s3", ex);
    hold_v1 = 1'b1;
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd15);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd5, "tmo_rails", e5);
    waitState(4'd15, "tmo_fault", ef);
    checkOutput("tmo_len", 32'(ef - e5), 32'd20);
    checkOutput("tmo_code", 32'({fault, fault_code}), 32'hA);
    checkOutput("tmo_outs", 32'(outVec()), 32'h80);
    stepCycle();
    pulseClear();
    repeat (4) stepCycle();
    checkOutput("clr_hold", 32'(state), 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) stepCycle();
    exp_q.push_back(4'd2);
    pulseClear();
    checkOutput("clr_s5", 32'(state), 32'd2);
    checkOutput("clr_fault", 32'({fault, fault_code}), 32'h2);
    hold_v1 = 1'b0;

    $display("[TB] rail loss in S0");
    for (int s = 3; s <= 8; s++) exp_q.push_back(4'(s));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd8, "loss_s0", ex);
    repeat (2) stepCycle();
    exp_q.push_back(4'd15);
    hold_apu = 1'b1;
    stepCycle();
    hold_apu = 1'b0;
    waitState(4'd15, "loss_fault", ex);
    checkOutput("loss_code", 32'({fault, fault_code}), 32'hC);
    checkOutput("loss_outs", 32'(outVec()), 32'h80);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) stepCycle();
    exp_q.push_back(4'd2);
    pulseClear();
    checkOutput("loss_clr", 32'(state), 32'd2);

    $display("[TB] DDR power-good on the last timeout cycle");
    hold_ddr = 1'b1;
    exp_q.push_back(4'd3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(4'd3, "bnd_ddr", eb);
    repeat (16) stepCycle();
    hold_ddr = 1'b0;
    exp_q.push_back(4'd4);
    stepCycle();
    waitState(4'd4, "bnd_s3", es);
    checkOutput("bnd_len", 32'(es - eb), 32'd20);
    checkOutput("bnd_fault", 32'(fault), 32'd0);

    $display("[TB] sleep during VRM");
    hold_apu = 1'b1;
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd6, "ab_vrm", ex);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitState(4'd9, "ab_dn", ex);
    checkOutput("ab_dn_outs", 32'(outVec()), 32'hF3);
    waitState(4'd4, "ab_s3", ex);
    checkOutput("ab_s3_outs", 32'(outVec()), 32'hE1);
    hold_apu = 1'b0;

    $display("[TB] enable drop and async reset");
    for (int s = 5; s <= 8; s++) exp_q.push_back(4'(s));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd8, "kill_s0", ex);
    exp_q.push_back(4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    ek = cyc;
    waitState(4'd0, "kill_off", eo);
    checkOutput("kill_lat", 32'(eo - ek), 32'd3);
    checkOutput("kill_outs", 32'(outVec()), 32'h00);
    hold_v1 = 1'b1;
    for (int s = 1; s <= 5; s++) exp_q.push_back(4'(s));
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitState(4'd5, "arst_rails", ex);
    checkOutput("rails_outs", 32'(outVec()), 32'hF3);
    stepCycle();
    exp_q.push_back(4'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_outs", 32'(outVec()), 32'h00);
    checkOutput("arst_state", 32'(state), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) stepCycle();
    rst_n = 1'b1;
    hold_v1 = 1'b0;
    repeat (5) stepCycle();
    checkOutput("final_state", 32'(state), 32'd0);
    checkOutput("seq_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
